mux_2to1_arbiter: RTL
=====================

# mux_2to1_arbiter

Round-robin arbiter that shares a 2:1 multiplexed data path between two requesters. It owns the mux select: it grants one requester at a time, steers that requester's data to a single output with a valid/ready handshake toward the consumer, and holds the grant for a whole burst. It sits between two producer ports and one downstream sink in the combinational-circuits area of the design.

## Interface
- DATA_W, 8, width of each data input and of y_out
- MAX_HOLD, 4, maximum beats per grant while the other side waits; only used with MUX_ARB_TIMEOUT_EN
- clk_in  input  1  clock; all state changes on the rising edge
- rst_in  input  1  reset, synchronous, active-high
- req0_in / req1_in  input  1  request from requester 0 / 1
- a_in / b_in  input  DATA_W  data of requester 0 / 1
- last0_in / last1_in  input  1  marks the final beat of the burst from requester 0 / 1
- ready_in  input  1  downstream can accept a beat
- gnt0_out / gnt1_out  output  1  grant to requester 0 / 1; one-hot or both 0
- sel_out  output  1  mux select; 0 = a_in, 1 = b_in
- y_out  output  DATA_W  the selected data: a_in when sel_out=0, b_in when sel_out=1
- valid_out  output  1  y_out holds a beat; equals (gnt0_out & req0_in) | (gnt1_out & req1_in)

## Operation
- FSM states: IDLE, GRANT0, GRANT1. gnt0_out=1 only in GRANT0, and gnt1_out=1 only in GRANT1.
- Priority pointer `last_srv` records which requester was served last. Reset value is 1, so requester 0 wins the first tie.
- IDLE:
  - If only one requester is asserted, grant it.
  - If both are asserted, grant the requester that is not `last_srv`.
  - If neither is asserted, stay in IDLE.
- Transfer: a beat moves when valid_out & ready_in.
- Release condition (GRANTx): any one of
  - a transfer with lastx_in=1;
  - reqx_in deasserted (abort);
  - a timeout, when the macro is enabled.
- Re-arbitration on release:
  - If the other requester is asserted, go directly to its GRANT state, with no IDLE bubble.
  - Else, if the same requester is still asserted, re-grant it.
  - Else, go to IDLE.
  - `last_srv` updates to the requester that was just released.
- sel_out updates on entry to GRANT0 (0) and GRANT1 (1). It holds its value in IDLE.
- Reset values: state=IDLE, gnt0_out=0, gnt1_out=0, sel_out=0, valid_out=0, `last_srv`=1, beat counter=0.
- Reset mid-burst: the grant drops on the next edge. No beat is transferred in that cycle's aftermath.

## Timing
- Request to grant: 1 cycle (req sampled at edge N, gnt visible after edge N).
- Data path: y_out and valid_out are combinational from the registered sel/gnt, with zero latency from a_in/b_in.
- Switch between requesters: the new grant is visible in the cycle immediately after the releasing transfer.
- ready_in=0 stalls a beat. The grant and sel_out hold, and y_out tracks the current input.
- With both requesters asserted continuously and single-beat bursts, grants alternate every cycle.

## Configuration
- MUX_ARB_TIMEOUT_EN defined:
  - A beat counter (width clog2(MAX_HOLD+1)) counts transfers in the current grant and clears on every grant entry.
  - When a transfer brings the count to MAX_HOLD while the other requester is asserted, that transfer releases the grant as if it carried last.
  - When the other requester is idle, no timeout occurs and the counter saturates.
- MUX_ARB_TIMEOUT_EN not defined: no counter is built, and the grant is held until last or abort.

## Structure
- Package mux_arb_pkg holds:
  - typedef arb_state_t for IDLE/GRANT0/GRANT1 (2-bit);
  - localparams for the state encodings;
  - the default MAX_HOLD.
- One sub-module: mux_2to1_bus, a combinational DATA_W-wide 2:1 mux driven by sel_out.

## Test plan
- Reset: hold rst_in=1 for 3 cycles with both req asserted -> all outputs 0; after release, gnt0_out=1 one cycle later.
- Single requester: req1_in=1, b_in=8'hA5, ready_in=1, last1_in on beat 3 -> gnt1_out after 1 cycle, sel_out=1, y_out=8'hA5, 3 transfers, then IDLE.
- Contention: both req held, each burst 2 beats -> grant sequence 0,0,1,1,0,0 with no idle cycle between bursts.
- Backpressure: ready_in=0 for 4 cycles mid-burst -> grant and sel_out stable, no transfer counted, burst resumes when ready_in=1.
- Abort: req0_in drops mid-burst while req1_in=1 -> gnt1_out next cycle, `last_srv`=0.
- Timeout (MUX_ARB_TIMEOUT_EN, MAX_HOLD=4): req0 has an 8-beat burst and req1 waits -> grant switches after beat 4. With req1 idle, all 8 beats complete without a switch.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encodings and defaults for mux_2to1_arbiter
package mux_arb_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;
    localparam int MAX_HOLD_DEF = 4;
    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        GRANT0 = ST_GRANT0,
        GRANT1 = ST_GRANT1
    } arb_state_t;
endpackage

// File: rtl/mux_2to1_arbiter_if.sv
// mux_2to1_arbiter_if: request/data/handshake bundle between two producers, the arbiter and one sink
// master: producer/sink side (drives req, data, last, ready); slave: arbiter side (drives gnt, sel, y, valid)
interface mux_2to1_arbiter_if #(parameter int DATA_W = 8);
    logic              req0_in, req1_in, last0_in, last1_in, ready_in;
    logic [DATA_W-1:0] a_in, b_in, y_out;
    logic              gnt0_out, gnt1_out, sel_out, valid_out;
    modport master (
        output req0_in, req1_in, last0_in, last1_in, ready_in, a_in, b_in,
        input  gnt0_out, gnt1_out, sel_out, valid_out, y_out
    );
    modport slave (
        input  req0_in, req1_in, last0_in, last1_in, ready_in, a_in, b_in,
        output gnt0_out, gnt1_out, sel_out, valid_out, y_out
    );
endinterface

// File: rtl/mux_2to1_bus.sv
// mux_2to1_bus: combinational DATA_W-wide 2:1 mux; sel_i=0 -> a_i, sel_i=1 -> b_i
module mux_2to1_bus #(parameter int DATA_W = 8) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/mux_2to1_arbiter.sv
// mux_2to1_arbiter: round-robin burst arbiter owning the select of a 2:1 data mux
// Ports: clk_in, rst_in (sync, active-high), bus (mux_2to1_arbiter_if.slave: req/last/data in, gnt/sel/y/valid out)
// Option: MUX_ARB_TIMEOUT_EN limits a grant to MAX_HOLD beats while the other side waits
module mux_2to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    mux_2to1_arbiter_if.slave  bus
);
    arb_state_t state_q, state_d;
    logic sel_q, sel_d, last_srv_q, last_srv_d;
    logic gnt0, gnt1, xfer, rel, to_hit;

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 1");
    end

    assign gnt0          = state_q == GRANT0;
    assign gnt1          = state_q == GRANT1;
    assign bus.gnt0_out  = gnt0;
    assign bus.gnt1_out  = gnt1;
    assign bus.sel_out   = sel_q;
    assign bus.valid_out = (gnt0 & bus.req0_in) | (gnt1 & bus.req1_in);
    assign xfer          = bus.valid_out & bus.ready_in;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             other_req;
    assign other_req = gnt0 ? bus.req1_in : bus.req0_in;
    // >= rather than == so a waiter that shows up after saturation still gets in on the next beat
    assign to_hit    = xfer & other_req & (cnt_q >= CNT_W'(MAX_HOLD - 1));
    assign cnt_d     = (state_q == IDLE || rel) ? '0
                     : (xfer && cnt_q != CNT_W'(MAX_HOLD)) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    assign rel = (gnt0 & ((xfer & bus.last0_in) | ~bus.req0_in))
               | (gnt1 & ((xfer & bus.last1_in) | ~bus.req1_in))
               | to_hit;

    always_comb begin
        state_d    = state_q;
        last_srv_d = last_srv_q;
        if (state_q == IDLE) begin
            state_d = (bus.req0_in & (~bus.req1_in | last_srv_q)) ? GRANT0
                    : bus.req1_in ? GRANT1 : IDLE;
        end else if (rel) begin
            last_srv_d = gnt1;
            // the waiting side goes first, then a re-grant of the same side
            state_d = gnt0 ? (bus.req1_in ? GRANT1 : bus.req0_in ? GRANT0 : IDLE)
                           : (bus.req0_in ? GRANT0 : bus.req1_in ? GRANT1 : IDLE);
        end
        sel_d = (state_d == GRANT0) ? 1'b0 : (state_d == GRANT1) ? 1'b1 : sel_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_srv_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_srv_q <= last_srv_d;
        end
    end

    mux_2to1_bus #(.DATA_W(DATA_W)) u_bus (
        .sel_i (sel_q),
        .a_i   (bus.a_in),
        .b_i   (bus.b_in),
        .y_o   (bus.y_out)
    );
endmodule
